// File: rtl/rv_writeback.sv
// Writeback stage: retires execute results and aligned load data into the register file.
// Latency: results appear on the register-file/bypass ports one cycle after acceptance or load completion.
// Backpressure: w_stall_o holds execute while a load is outstanding; inputs are ignored while stalled.
module rv_writeback #(
    parameter int g_with_instret = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,

    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,

    output logic        w_stall_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic [63:0] instret_o
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

    logic [0:0]  r_state;

    // Parameters of the outstanding load, captured when it is accepted
    logic [4:0]  r_ld_rd;
    logic        r_ld_write;
    logic [2:0]  r_ld_fun;
    logic [1:0]  r_ld_addr;

    logic [4:0]  r_rd;
    logic [31:0] r_rd_value;
    logic        r_rd_write;
    logic [63:0] r_instret;

    logic        w_accept;
    logic        w_load_done;
    logic        w_retire;
    logic        w_alu_wr;
    logic        w_ld_wr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;

    // A new instruction is only taken while idle; a completion only counts while waiting
    assign w_accept    = (r_state == ST_IDLE) && x_valid_i;
    assign w_load_done = (r_state == ST_WAIT_LOAD) && dm_load_done_i;
    assign w_retire    = (w_accept && !x_load_i) || w_load_done;

    // Writes to x0 are suppressed so the register file never sees them
    assign w_alu_wr = x_rd_write_i && (x_rd_i != 5'd0);
    assign w_ld_wr  = r_ld_write && (r_ld_rd != 5'd0);

    // Select the addressed byte and half-word from the raw memory word
    always_comb begin
        w_byte = dm_data_l_i[7:0];
        case (r_ld_addr)
            2'b00:   w_byte = dm_data_l_i[7:0];
            2'b01:   w_byte = dm_data_l_i[15:8];
            2'b10:   w_byte = dm_data_l_i[23:16];
            default: w_byte = dm_data_l_i[31:24];
        endcase
        w_half = r_ld_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    end

    // Extend the selected field by load type; word and reserved encodings pass through
    always_comb begin
        w_load_value = dm_data_l_i;
        case (r_ld_fun)
            3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_value = {24'd0, w_byte};
            3'b101:  w_load_value = {16'd0, w_half};
            default: w_load_value = dm_data_l_i;
        endcase
    end

    // State machine, load capture and register-file output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ld_rd    <= 5'd0;
            r_ld_write <= 1'b0;
            r_ld_fun   <= 3'd0;
            r_ld_addr  <= 2'd0;
            r_rd       <= 5'd0;
            r_rd_value <= 32'd0;
            r_rd_write <= 1'b0;
        end else begin
            r_rd_write <= 1'b0;
            if (w_accept) begin
                if (x_load_i) begin
                    r_ld_rd    <= x_rd_i;
                    r_ld_write <= x_rd_write_i;
                    r_ld_fun   <= x_fun_i;
                    r_ld_addr  <= x_dm_addr_i;
                    r_state    <= ST_WAIT_LOAD;
                end else begin
                    r_rd_write <= w_alu_wr;
                    // Address/data only move on a real write so they hold otherwise
                    if (w_alu_wr) begin
                        r_rd       <= x_rd_i;
                        r_rd_value <= x_rd_value_i;
                    end
                end
            end else if (w_load_done) begin
                r_rd_write <= w_ld_wr;
                if (w_ld_wr) begin
                    r_rd       <= r_ld_rd;
                    r_rd_value <= w_load_value;
                end
                r_state <= ST_IDLE;
            end
        end
    end

    generate
        if (g_with_instret != 0) begin : g_instret
            // Retired-instruction counter, wraps naturally at 2^64
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_instret <= 64'd0;
                end else if (w_retire) begin
                    r_instret <= r_instret + 64'd1;
                end
            end
        end else begin : g_no_instret
            assign r_instret = 64'd0;
        end
    endgenerate

    assign w_stall_o           = (r_state == ST_WAIT_LOAD);
    assign rf_rd_o             = r_rd;
    assign rf_rd_value_o       = r_rd_value;
    assign rf_rd_write_o       = r_rd_write;
    assign w_bypass_rd_write_o = r_rd_write;
    assign w_bypass_rd_value_o = r_rd_value;
    assign instret_o           = r_instret;

endmodule

// File: doc/rv_writeback.md
Name: rv_writeback

Overview:
- Writeback (W) stage of the uRV pipeline.
- Takes retiring results from the execute stage and aligns and sign-extends load data from the data-memory port.
- Drives the register-file write port and the W-stage bypass port.
- Stalls the pipeline while a load is outstanding.
- Optionally counts retired instructions.

Parameters:
g_with_instret, 1, 1 = implement 64-bit retired-instruction counter; 0 = instret_o tied to 0.

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous, active-high reset
x_valid_i  in  1  execute stage presents a retiring instruction this cycle
x_rd_i  in  5  destination register
x_rd_value_i  in  32  result for non-load instructions
x_rd_write_i  in  1  instruction writes rd
x_load_i  in  1  instruction is a load
x_fun_i  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
x_dm_addr_i  in  2  low bits of the load effective address
dm_data_l_i  in  32  raw word read from data memory
dm_load_done_i  in  1  load data valid (single-cycle pulse)
w_stall_o  out  1  W busy; execute must hold its outputs
rf_rd_o  out  5  register-file write address
rf_rd_value_o  out  32  register-file write data
rf_rd_write_o  out  1  register-file write strobe
w_bypass_rd_write_o  out  1  bypass valid for the decode/execute operand mux
w_bypass_rd_value_o  out  32  bypass data
instret_o  out  64  retired instruction count

Behaviour:
- States: IDLE, WAIT_LOAD. w_stall_o = (state == WAIT_LOAD), combinational from state only.
- Reset (async):
  - State goes to IDLE.
  - rf_rd_o = 0, rf_rd_value_o = 0, rf_rd_write_o = 0, bypass outputs = 0, instret_o = 0.
  - Any pending load is discarded.
- Accept rule: an instruction is accepted only in IDLE with x_valid_i = 1. x_valid_i is ignored in WAIT_LOAD.
- IDLE, accept, x_load_i = 0:
  - Next cycle: rf_rd_o = x_rd_i, rf_rd_value_o = x_rd_value_i.
  - rf_rd_write_o = x_rd_write_i && (x_rd_i != 0), high for exactly one cycle.
  - instret increments.
- IDLE, accept, x_load_i = 1:
  - Latch rd, x_rd_write_i, fun, addr into load registers; state goes to WAIT_LOAD.
  - rf_rd_write_o = 0 next cycle.
  - dm_load_done_i in the acceptance cycle is ignored; the response always arrives at least one cycle later.
- WAIT_LOAD, dm_load_done_i = 1:
  - Next cycle: rf_rd_value_o = aligned(dm_data_l_i); rf_rd_write_o = latched write && (latched rd != 0).
  - State goes to IDLE; instret increments; w_stall_o drops on that same next cycle.
  - The new instruction may be accepted on the cycle w_stall_o is low.
- WAIT_LOAD with no done: hold indefinitely; no outputs change except rf_rd_write_o = 0.
- Alignment:
  - LB/LBU select byte addr[1:0] (00 = bits 7:0 … 11 = bits 31:24); LB sign-extends, LBU zero-extends.
  - LH/LHU select the half by addr[1] (0 = bits 15:0, 1 = bits 31:16); LH sign-extends, LHU zero-extends. addr[0] is ignored.
  - LW and reserved funct3 (011, 110, 111) pass the word unmodified.
- Output registers:
  - rf_rd_o / rf_rd_value_o hold their last value when rf_rd_write_o = 0.
  - Bypass outputs equal rf_rd_write_o / rf_rd_value_o in the same cycle, so a write and its bypass are always coherent.
- Counter: instret_o is 64-bit and wraps from 2^64-1 to 0. It counts loads to x0 and instructions with x_rd_write_i = 0.
- dm_load_done_i while in IDLE is ignored.
- Back-to-back non-loads produce one write per cycle with no bubbles.

Test Plan:
- Reset: assert rst_i mid-WAIT_LOAD without clock → all outputs 0, w_stall_o = 0 immediately; a later dm_load_done_i produces no write.
- ALU stream: x_valid_i for 3 cycles, rd = 1/2/3, values 0xA/0xB/0xC → rf_rd_write_o high 3 consecutive cycles with matching rd/value, bypass identical, instret_o = 3.
- Load alignment: dm_data_l_i = 0x80FF7F01 with completed loads (values = written data) →
  - LB addr 3 → 0xFFFFFF80.
  - LBU addr 3 → 0x00000080.
  - LH addr 2 → 0xFFFF80FF.
  - LHU addr 0 → 0x00007F01.
  - LB addr 1 → 0x0000007F.
  - LW → 0x80FF7F01.
- Load stall: LW rd = 5, dm_load_done_i after 4 cycles → w_stall_o high exactly 4 cycles; write rd 5 on the cycle after done; a held ALU instruction is accepted that cycle and written the following cycle.
- x0 protection: ALU rd = 0 with write = 1, and load rd = 0 → rf_rd_write_o never asserts; instret_o still increments by 2.
- Spurious done: dm_load_done_i pulse in IDLE → no write, no state change.
